seq_detect_prog: RTL

Programmable serial bit-pattern detector, the parametrised successor to the fixed "110" Mealy/Moore detectors. It matches a runtime-loadable pattern of 1..MAX_LEN bits on a qualified serial stream, in overlapping or non-overlapping mode. It provides a combinational Mealy match, a registered glitch-free match and a saturating match counter. It sits between a serial front end (deserialiser or UART bit output) and control logic that reacts to frame or sync markers.

---
 rtl/seq_detect_prog.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: detects a serial bit pattern whose length and bits are
// loaded at runtime. The match can overlap the previous one or not. It
// provides a Mealy match, a registered match and a saturating match count.
module seq_detect_prog #(
    parameter int unsigned          MAX_LEN = 8,
    parameter int unsigned          CNT_W   = 8,
    parameter logic [MAX_LEN-1:0]   RST_PAT = 8'b0000_0110,
    parameter int unsigned          RST_LEN = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          x,
    input  logic                          x_valid,
    input  logic                          overlap,
    input  logic                          load,
    input  logic [MAX_LEN-1:0]            pat_in,
    input  logic [$clog2(MAX_LEN+1)-1:0]  len_in,
    input  logic                          cnt_clr,
    output logic                          match,
    output logic                          match_q,
    output logic [CNT_W-1:0]              match_count,
    output logic                          active
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned HIS_W = MAX_LEN - 1;
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic [HIS_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               active_q, active_d;
    logic               match_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;

    logic               accept;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               enough;

    // State registers; reset restores the power-on pattern and clears history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q    <= RST_PAT;
            len_q    <= LEN_W'(RST_LEN);
            hist_q   <= '0;
            fill_q   <= '0;
            active_q <= 1'b1;
            match_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pat_q    <= pat_d;
            len_q    <= len_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            active_q <= active_d;
            match_q  <= match_d;
            cnt_q    <= cnt_d;
        end
    end

    // Mealy match: the newest len_q bits (history plus current x) against the pattern
    always_comb begin
        accept = x_valid & ~load;
        window = {hist_q, x};
        mask   = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < 32'(len_q)) begin
                mask[i] = 1'b1;
            end
        end
        enough = (32'(fill_q) + 32'd1) >= 32'(len_q);
        match  = active_q & accept & enough & (((window ^ pat_q) & mask) == '0);
    end

    // Next-state: pattern load, history shift, fill tracking, counter
    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        active_d = active_q;
        match_d  = match;
        cnt_d    = cnt_q;

        if (load) begin
            pat_d    = pat_in;
            len_d    = len_in;
            hist_d   = '0;
            fill_d   = '0;
            active_d = (len_in != '0) && (32'(len_in) <= MAX_LEN);
        end else if (accept) begin
            hist_d = HIS_W'({hist_q, x});
            if (match && !overlap) begin
                // Non-overlapping: the completing bit cannot seed another match
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign match_count = cnt_q;
    assign active      = active_q;

endmodule
